uart_baud_gen_frac: RTL
=======================

Name: uart_baud_gen_frac

Overview:
Runtime-programmable UART baud generator with a fractional-N divider and a configurable oversampling ratio (OSR).
It produces an oversample tick, a per-bit tick and a mid-bit sample tick.
It feeds both the UART TX shifter and the RX sampler, and replaces the fixed compile-time divider.
The RX path can re-align the bit phase to a detected start-bit edge via the restart input.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency; used only for the reset-default divisor.
DEFAULT_BAUD, 115200, baud rate loaded at reset.
OSR_MAX, 16, maximum oversampling ratio; also the reset-default OSR.
DIV_INT_W, 16, width of the integer divisor.
FRAC_W, 4, width of the fractional divisor (resolution 1/2^FRAC_W clock).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  count enable; when low, counters hold and no ticks are produced
restart  in  1  phase resync pulse: clears counters and phase
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  configuration slot free
cfg_div_int  in  DIV_INT_W  integer cycles per oversample period
cfg_div_frac  in  FRAC_W  fractional cycles per oversample period
cfg_osr  in  OSR_W=$clog2(OSR_MAX+1)  oversample periods per bit
tick_os  out  1  one-cycle pulse per oversample period
tick_bit  out  1  one-cycle pulse per bit; coincident with the tick_os that wraps os_phase to 0
tick_mid  out  1  one-cycle pulse with the tick_os where os_phase becomes osr/2 (integer division)
os_phase  out  OSR_W  current oversample index, range 0..osr-1

Behaviour:
- Reset:
  - tick_os = tick_bit = tick_mid = 0; os_phase = 0; cfg_ready = 1.
  - Counter and fractional accumulator = 0.
  - Active divisor = round(CLK_FREQ_HZ*2^FRAC_W/(DEFAULT_BAUD*OSR_MAX)), split into int/frac. Defaults give 434, i.e. div_int=27, frac=2.
  - osr = OSR_MAX.
- Fractional divider:
  - Each oversample period lasts P = div_int + carry cycles.
  - carry is the overflow of acc + div_frac (FRAC_W-bit add).
  - acc updates on every tick_os.
  - Mean period = div_int + div_frac/2^FRAC_W.
- Tick timing:
  - All ticks are registered.
  - tick_os rises exactly P enabled clock edges after the edge that samples restart, or after rst deasserts.
  - Subsequent ticks follow every P enabled edges.
  - Cycles with en=0 do not count, and all ticks are forced to 0 in those cycles.
- os_phase:
  - Increments on each tick_os; wraps from osr-1 to 0.
  - The wrapping tick_os also asserts tick_bit.
  - The tick_os that sets os_phase to osr/2 also asserts tick_mid.
- restart:
  - Sampled at the edge: counter, acc and os_phase are cleared to 0, and no tick is emitted that cycle.
  - Has priority over a coincident terminal count.
  - Ignored while en=0? No: it still clears state.
- Config handshake:
  - Transfer happens when cfg_valid && cfg_ready. Values are captured into a pending register and cfg_ready drops next cycle.
  - Pending config is applied at the next bit boundary (the edge producing tick_bit), or on the next edge if en=0 or restart=1.
  - On apply: acc, counter and os_phase are cleared, and cfg_ready returns to 1 the following cycle.
  - A second cfg_valid while cfg_ready=0 is not accepted; the master holds it.
- Clamping at capture:
  - cfg_div_int < 2 becomes 2.
  - cfg_osr < 4 becomes 4; cfg_osr > OSR_MAX becomes OSR_MAX.
  - cfg_div_frac is applied unchanged.
- Reset mid-operation: asynchronously returns everything to the reset defaults, including discarding any pending config.

Decomposition:
- Package uart_pkg:
  - OSR_W localparam.
  - uart_baud_cfg_t struct {div_int, div_frac, osr}.
  - Function baud_default_div(clk, baud, osr) returning the rounded fixed-point divisor.
  - Clamp constants MIN_DIV_INT=2, MIN_OSR=4.
- Sub-module uart_frac_divider:
  - Contains the counter and accumulator.
  - Inputs: en, clear, div_int, div_frac. Output: tick.
- The top level holds the config handshake, phase counter and tick decode.

Test Plan:
- Reset defaults, en=1 held 5000 cycles -> each tick_os gap is 27 or 28 cycles; every 16 ticks contain exactly two 28-cycle gaps; each tick_bit gap is 434 cycles.
- Config div_int=10, frac=0, osr=8 written mid-bit -> cfg_ready low until the next tick_bit; afterwards tick_os every 10 cycles and tick_bit every 80; tick_mid when os_phase becomes 4.
- restart pulsed with os_phase=9 -> no ticks on that edge; os_phase=0; next tick_os exactly div_int edges later with os_phase=1.
- en low for 50 cycles mid-period -> no ticks while low; the period resumes and the tick arrives after the remaining count.
- Config div_int=1, osr=2 -> clamped to 2 and 4: tick_os every 2 cycles, tick_bit every 8.
- Assert rst while a config is pending -> cfg_ready=1, all ticks 0, default 434-cycle bit period restored.

Source files
------------

// File: rtl/uart_baud_gen_frac_pkg.sv
// Shared types, widths and helpers for the fractional-N UART baud generator.
package uart_pkg;

   localparam int unsigned UART_DIV_INT_W = 16;
   localparam int unsigned UART_FRAC_W    = 4;
   localparam int unsigned UART_OSR_MAX   = 16;
   localparam int unsigned OSR_W          = $clog2(UART_OSR_MAX + 1);
   localparam int unsigned MIN_DIV_INT    = 2;
   localparam int unsigned MIN_OSR        = 4;

   typedef struct packed {
      logic [UART_DIV_INT_W-1:0] div_int;
      logic [UART_FRAC_W-1:0]    div_frac;
      logic [OSR_W-1:0]          osr;
   } uart_baud_cfg_t;

   typedef enum logic {
      CFG_IDLE,
      CFG_PENDING
   } cfg_state_e;

   // Rounded fixed-point divisor: clk * 2^frac_w / (baud * osr).
   function automatic longint unsigned baud_default_div(input longint unsigned clk_hz,
                                                        input longint unsigned baud,
                                                        input longint unsigned osr,
                                                        input longint unsigned frac_w);
      longint unsigned den;
      den = baud * osr;
      return ((clk_hz << frac_w) + (den / 2)) / den;
   endfunction

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Configuration handshake between the UART control logic and the baud generator.
interface uart_baud_gen_frac_if #(
   parameter int unsigned DIV_INT_W = 16,
   parameter int unsigned FRAC_W    = 4,
   parameter int unsigned OSR_W     = 5
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [DIV_INT_W-1:0] cfg_div_int;
   logic [FRAC_W-1:0]    cfg_div_frac;
   logic [OSR_W-1:0]     cfg_osr;

   modport master (output cfg_valid, cfg_div_int, cfg_div_frac, cfg_osr, input cfg_ready);
   modport slave  (input cfg_valid, cfg_div_int, cfg_div_frac, cfg_osr, output cfg_ready);
endinterface

// File: rtl/uart_baud_gen_frac_divider.sv
// Fractional-N period counter: each period lasts div_int cycles plus the
// carry of a FRAC_W-bit phase accumulator; tick flags the terminal cycle.
module uart_frac_divider #(
   parameter int unsigned DIV_INT_W = 16,
   parameter int unsigned FRAC_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 clear,
   input  logic [DIV_INT_W-1:0] div_int,
   input  logic [FRAC_W-1:0]    div_frac,
   output logic                 tick
);

   logic [DIV_INT_W-1:0] cnt_q, cnt_d;
   logic [FRAC_W-1:0]    acc_q, acc_d;
   logic [FRAC_W:0]      acc_sum;
   logic [DIV_INT_W:0]   period;
   logic [DIV_INT_W:0]   cnt_next;

   always_comb begin
      acc_sum  = {1'b0, acc_q} + {1'b0, div_frac};
      period   = {1'b0, div_int} + {{DIV_INT_W{1'b0}}, acc_sum[FRAC_W]};
      cnt_next = {1'b0, cnt_q} + (DIV_INT_W + 1)'(1);
      tick     = en && (cnt_next == period);
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      if (clear) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (tick) begin
         cnt_d = '0;
         acc_d = acc_sum[FRAC_W-1:0];
      end else if (en) begin
         cnt_d = cnt_next[DIV_INT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Runtime-programmable UART baud generator: config handshake, oversample
// phase counter and registered tick decode around a fractional divider.
module uart_baud_gen_frac
   import uart_pkg::*;
#(
   parameter int unsigned  CLK_FREQ_HZ  = 50_000_000,
   parameter int unsigned  DEFAULT_BAUD = 115_200,
   parameter int unsigned  OSR_MAX      = UART_OSR_MAX,
   parameter int unsigned  DIV_INT_W    = UART_DIV_INT_W,
   parameter int unsigned  FRAC_W       = UART_FRAC_W,
   localparam int unsigned OSR_W_L      = $clog2(OSR_MAX + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 restart,
   uart_baud_gen_frac_if.slave  cfg,
   output logic                 tick_os,
   output logic                 tick_bit,
   output logic                 tick_mid,
   output logic [OSR_W_L-1:0]   os_phase
);

   localparam longint unsigned DEF_DIV = baud_default_div(64'(CLK_FREQ_HZ), 64'(DEFAULT_BAUD),
                                                          64'(OSR_MAX), 64'(FRAC_W));
   localparam uart_baud_cfg_t DEF_CFG = '{div_int:  DIV_INT_W'(DEF_DIV >> FRAC_W),
                                          div_frac: FRAC_W'(DEF_DIV),
                                          osr:      OSR_W_L'(OSR_MAX)};

   cfg_state_e           state_q, state_d;
   uart_baud_cfg_t       active_q, active_d;
   uart_baud_cfg_t       pend_q, pend_d;
   uart_baud_cfg_t       cap;
   logic [OSR_W_L-1:0]   os_phase_q, os_phase_d;
   logic [OSR_W_L-1:0]   phase_next;
   logic                 tick_os_q, tick_os_d;
   logic                 tick_bit_q, tick_bit_d;
   logic                 tick_mid_q, tick_mid_d;
   logic                 div_tick, div_clear;
   logic                 tick_fire, at_wrap, bit_fire, apply;

   uart_frac_divider #(
      .DIV_INT_W (DIV_INT_W),
      .FRAC_W    (FRAC_W)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .clear    (div_clear),
      .div_int  (active_q.div_int),
      .div_frac (active_q.div_frac),
      .tick     (div_tick)
   );

   always_comb begin
      tick_fire  = div_tick && !restart;
      at_wrap    = (os_phase_q == active_q.osr - OSR_W_L'(1));
      bit_fire   = tick_fire && at_wrap;
      // Pending config lands on the bit boundary, or immediately when idle/resyncing.
      apply      = (state_q == CFG_PENDING) && (bit_fire || !en || restart);
      div_clear  = restart || apply;
      phase_next = at_wrap ? '0 : os_phase_q + OSR_W_L'(1);

      os_phase_d = os_phase_q;
      if (tick_fire) os_phase_d = phase_next;
      if (div_clear) os_phase_d = '0;

      tick_os_d  = tick_fire;
      tick_bit_d = bit_fire;
      tick_mid_d = tick_fire && (phase_next == (active_q.osr >> 1));

      cap.div_frac = cfg.cfg_div_frac;
      cap.div_int  = (cfg.cfg_div_int < DIV_INT_W'(MIN_DIV_INT)) ? DIV_INT_W'(MIN_DIV_INT)
                                                                 : cfg.cfg_div_int;
      if (cfg.cfg_osr < OSR_W_L'(MIN_OSR))       cap.osr = OSR_W_L'(MIN_OSR);
      else if (cfg.cfg_osr > OSR_W_L'(OSR_MAX))  cap.osr = OSR_W_L'(OSR_MAX);
      else                                       cap.osr = cfg.cfg_osr;

      state_d  = state_q;
      pend_d   = pend_q;
      active_d = active_q;
      case (state_q)
         CFG_IDLE: begin
            if (cfg.cfg_valid) begin
               pend_d  = cap;
               state_d = CFG_PENDING;
            end
         end
         CFG_PENDING: begin
            if (apply) begin
               active_d = pend_q;
               state_d  = CFG_IDLE;
            end
         end
         default: state_d = CFG_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CFG_IDLE;
         active_q   <= DEF_CFG;
         pend_q     <= DEF_CFG;
         os_phase_q <= '0;
         tick_os_q  <= 1'b0;
         tick_bit_q <= 1'b0;
         tick_mid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         active_q   <= active_d;
         pend_q     <= pend_d;
         os_phase_q <= os_phase_d;
         tick_os_q  <= tick_os_d;
         tick_bit_q <= tick_bit_d;
         tick_mid_q <= tick_mid_d;
      end
   end

   assign cfg.cfg_ready = (state_q == CFG_IDLE);
   assign tick_os       = tick_os_q;
   assign tick_bit      = tick_bit_q;
   assign tick_mid      = tick_mid_q;
   assign os_phase      = os_phase_q;

endmodule
